// File: rtl/iopmp_pkg.sv
// Shared IOPMP types: access kinds, entry config, error record, checker FSM states.
package iopmp_pkg;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'b00,
    ACCESS_READ  = 2'b01,
    ACCESS_WRITE = 2'b10
  } iopmp_access_t;

  typedef enum logic [1:0] {
    ADDR_OFF   = 2'b00,
    ADDR_TOR   = 2'b01,
    ADDR_NA4   = 2'b10,
    ADDR_NAPOT = 2'b11
  } iopmp_addr_mode_t;

  typedef struct packed {
    iopmp_addr_mode_t addr_mode;
    logic             w;
    logic             r;
  } iopmp_entry_t;

  typedef struct packed {
    logic [13:0] sid;
    logic [12:0] length;
    logic        read;
    logic [2:0]  extra;
    logic        illcgt;
  } iopmp_rcd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOOKUP = 2'b01,
    ST_SCAN   = 2'b10,
    ST_RESP   = 2'b11
  } iopmp_state_t;

  localparam logic [2:0] EXTRA_NO_HIT  = 3'b000;
  localparam logic [2:0] EXTRA_PERM    = 3'b001;
  localparam logic [2:0] EXTRA_PARTIAL = 3'b010;

endpackage

// File: rtl/iopmp_entry_match.sv
// Combinational range match of byte range [lo, hi] against one TOR/NA4/NAPOT entry.
// Zero latency, no flow control; addresses widened by 2 bits so entry<<2 never truncates.
module iopmp_entry_match
  import iopmp_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic [AW+1:0]     lo_i,
  input  logic [AW+1:0]     hi_i,
  input  logic [AW-1:0]     entry_addr_i,
  input  logic [AW-1:0]     prev_addr_i,
  input  iopmp_addr_mode_t  mode_i,
  output logic              full_o,
  output logic              partial_o
);

  localparam int XW = AW + 2;

  logic [AW-1:0] napot_mask;
  logic [XW-1:0] base;
  logic [XW-1:0] top;
  logic [XW-1:0] tor_end;
  logic          region_vld;
  logic          overlap;

  always_comb begin
    // Trailing ones plus the first zero above them give the NAPOT size mask.
    napot_mask = entry_addr_i ^ (entry_addr_i + AW'(1));
    tor_end    = {entry_addr_i, 2'b00};
    base       = '0;
    top        = '0;
    region_vld = 1'b0;
    case (mode_i)
      ADDR_TOR: begin
        base       = {prev_addr_i, 2'b00};
        top        = tor_end - XW'(1);
        region_vld = base < tor_end;
      end
      ADDR_NA4: begin
        base       = {entry_addr_i, 2'b00};
        top        = {entry_addr_i, 2'b11};
        region_vld = 1'b1;
      end
      ADDR_NAPOT: begin
        base       = {entry_addr_i & ~napot_mask, 2'b00};
        top        = {entry_addr_i | napot_mask, 2'b11};
        region_vld = 1'b1;
      end
      default: ;
    endcase
    full_o    = region_vld && (lo_i >= base) && (hi_i <= top);
    overlap   = region_vld && (lo_i <= top) && (hi_i >= base);
    partial_o = overlap && !full_o;
  end

endmodule

// File: rtl/iopmp_check_seq.sv
// Sequential IOPMP checker: walks memory domains/entries one per cycle, lowest matching entry wins.
// Latency 1 (disabled/illegal) to 2+NR_ENTRIES+NR_MD cycles; one request in flight, response held until rsp_ready_i.
module iopmp_check_seq
  import iopmp_pkg::*;
#(
  parameter int NR_MD      = 63,
  parameter int NR_ENTRIES = 32,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [12:0]             req_len_i,
  input  iopmp_access_t           req_access_i,
  input  logic [13:0]             req_sid_i,
  output logic [13:0]             srcmd_sid_o,
  input  logic [62:0]             srcmd_md_i,
  input  logic [NR_MD*16-1:0]     mdcfg_t_i,
  output logic [4:0]              entry_idx_o,
  input  logic [ADDR_WIDTH-1:0]   entry_addr_i,
  input  logic [ADDR_WIDTH-1:0]   entry_prev_addr_i,
  input  iopmp_entry_t            entry_cfg_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_allow_o,
  output logic                    rsp_hit_o,
  output logic [4:0]              rsp_entry_o,
  output logic                    rcd_we_o,
  output iopmp_rcd_t              rcd_o,
  output logic [ADDR_WIDTH-1:0]   rcd_addr_o
);

  localparam int         XW      = ADDR_WIDTH + 2;
  localparam logic [5:0] IDX_END = 6'(NR_ENTRIES);
  localparam logic [5:0] MD_END  = 6'(NR_MD);

  iopmp_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [12:0]           len_q, len_d;
  iopmp_access_t         access_q, access_d;
  logic [13:0]           sid_q, sid_d;
  logic [62:0]           md_vec_q, md_vec_d;
  logic [5:0]            idx_q, idx_d;
  logic [5:0]            md_q, md_d;
  logic                  hit_q, hit_d;
  logic                  full_q, full_d;
  logic                  perm_q, perm_d;
  logic [4:0]            entry_q, entry_d;
  logic                  allow_q, allow_d;
  logic [2:0]            extra_q, extra_d;
  logic                  illcgt_q, illcgt_d;
  logic                  rcd_we_q, rcd_we_d;

  logic [15:0]   cur_t;
  logic [XW-1:0] lo;
  logic [XW-1:0] hi;
  logic          m_full;
  logic          m_partial;
  logic          considered;
  logic          perm;

  always_comb begin
    cur_t = '0;
    for (int k = 0; k < NR_MD; k++) begin
      if (md_q == 6'(k)) cur_t = mdcfg_t_i[k*16 +: 16];
    end
  end

  assign lo = {2'b00, addr_q};
  assign hi = lo + XW'(len_q);

  iopmp_entry_match #(.AW(ADDR_WIDTH)) u_match (
    .lo_i         (lo),
    .hi_i         (hi),
    .entry_addr_i (entry_addr_i),
    .prev_addr_i  (entry_prev_addr_i),
    .mode_i       (entry_cfg_i.addr_mode),
    .full_o       (m_full),
    .partial_o    (m_partial)
  );

  assign considered = (entry_cfg_i.addr_mode != ADDR_OFF) && md_vec_q[md_q];
  assign perm       = (access_q == ACCESS_READ) ? entry_cfg_i.r : entry_cfg_i.w;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    access_d = access_q;
    sid_d    = sid_q;
    md_vec_d = md_vec_q;
    idx_d    = idx_q;
    md_d     = md_q;
    hit_d    = hit_q;
    full_d   = full_q;
    perm_d   = perm_q;
    entry_d  = entry_q;
    allow_d  = allow_q;
    extra_d  = extra_q;
    illcgt_d = illcgt_q;
    rcd_we_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          len_d    = req_len_i;
          access_d = req_access_i;
          sid_d    = req_sid_i;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        hit_d    = 1'b0;
        entry_d  = '0;
        extra_d  = EXTRA_NO_HIT;
        illcgt_d = 1'b0;
        if (!enable_i) begin
          allow_d = 1'b1;
          state_d = ST_RESP;
        end else if (access_q != ACCESS_READ && access_q != ACCESS_WRITE) begin
          allow_d  = 1'b0;
          illcgt_d = 1'b1;
          rcd_we_d = 1'b1;
          state_d  = ST_RESP;
        end else begin
          md_vec_d = srcmd_md_i;
          idx_d    = '0;
          md_d     = '0;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // A match found last cycle terminates the scan before any further index is used.
        if (hit_q) begin
          allow_d  = full_q && perm_q;
          extra_d  = !full_q ? EXTRA_PARTIAL : (perm_q ? EXTRA_NO_HIT : EXTRA_PERM);
          rcd_we_d = !(full_q && perm_q);
          state_d  = ST_RESP;
        end else if (idx_q >= IDX_END || md_q >= MD_END) begin
          allow_d  = 1'b0;
          extra_d  = EXTRA_NO_HIT;
          rcd_we_d = 1'b1;
          state_d  = ST_RESP;
        end else if ({10'b0, idx_q} >= cur_t) begin
          md_d = md_q + 6'd1;
        end else begin
          if (considered && (m_full || m_partial)) begin
            hit_d   = 1'b1;
            full_d  = m_full;
            perm_d  = perm;
            entry_d = idx_q[4:0];
          end
          idx_d = idx_q + 6'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      access_q <= ACCESS_NONE;
      sid_q    <= '0;
      md_vec_q <= '0;
      idx_q    <= '0;
      md_q     <= '0;
      hit_q    <= 1'b0;
      full_q   <= 1'b0;
      perm_q   <= 1'b0;
      entry_q  <= '0;
      allow_q  <= 1'b0;
      extra_q  <= '0;
      illcgt_q <= 1'b0;
      rcd_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      access_q <= access_d;
      sid_q    <= sid_d;
      md_vec_q <= md_vec_d;
      idx_q    <= idx_d;
      md_q     <= md_d;
      hit_q    <= hit_d;
      full_q   <= full_d;
      perm_q   <= perm_d;
      entry_q  <= entry_d;
      allow_q  <= allow_d;
      extra_q  <= extra_d;
      illcgt_q <= illcgt_d;
      rcd_we_q <= rcd_we_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign srcmd_sid_o = sid_q;
  assign entry_idx_o = idx_q[4:0];
  assign rsp_allow_o = allow_q;
  assign rsp_hit_o   = hit_q;
  assign rsp_entry_o = entry_q;
  assign rcd_we_o    = rcd_we_q;
  assign rcd_addr_o  = addr_q;

  always_comb begin
    rcd_o        = '0;
    rcd_o.sid    = sid_q;
    rcd_o.length = len_q;
    rcd_o.read   = (access_q == ACCESS_READ);
    rcd_o.extra  = extra_q;
    rcd_o.illcgt = illcgt_q;
  end

endmodule

// File: tb/tb_iopmp_check_seq.sv
// Scoreboard bench for iopmp_check_seq: directed cases plus random config/requests vs a range-level model.
module tb_iopmp_check_seq;
  import iopmp_pkg::*;

  localparam int NR_MD = 63;
  localparam int NR_ENTRIES = 32;
  localparam int AW = 64;
  localparam int LAT_MAX = 2 + NR_ENTRIES + NR_MD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                enable_i = 1'b0;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic [AW-1:0]       req_addr_i = '0;
  logic [12:0]         req_len_i = '0;
  iopmp_access_t       req_access_i = ACCESS_NONE;
  logic [13:0]         req_sid_i = '0;
  logic [13:0]         srcmd_sid_o;
  logic [62:0]         srcmd_md_i;
  logic [NR_MD*16-1:0] mdcfg_t_i;
  logic [4:0]          entry_idx_o;
  logic [AW-1:0]       entry_addr_i;
  logic [AW-1:0]       entry_prev_addr_i;
  iopmp_entry_t        entry_cfg_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i = 1'b0;
  logic                rsp_allow_o;
  logic                rsp_hit_o;
  logic [4:0]          rsp_entry_o;
  logic                rcd_we_o;
  iopmp_rcd_t          rcd_o;
  logic [AW-1:0]       rcd_addr_o;

  logic [AW-1:0] ent_addr [NR_ENTRIES];
  iopmp_entry_t  ent_cfg  [NR_ENTRIES];
  logic [15:0]   mdt      [NR_MD];
  logic [62:0]   srcmd_tab [16];

  assign srcmd_md_i        = srcmd_tab[srcmd_sid_o[3:0]];
  assign entry_addr_i      = ent_addr[entry_idx_o];
  assign entry_prev_addr_i = (entry_idx_o == 5'd0) ? '0 : ent_addr[entry_idx_o - 5'd1];
  assign entry_cfg_i       = ent_cfg[entry_idx_o];
  for (genvar g = 0; g < NR_MD; g++) begin : g_mdt
    assign mdcfg_t_i[g*16 +: 16] = mdt[g];
  end

  iopmp_check_seq #(.NR_MD(NR_MD), .NR_ENTRIES(NR_ENTRIES), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .req_access_i(req_access_i), .req_sid_i(req_sid_i),
    .srcmd_sid_o(srcmd_sid_o), .srcmd_md_i(srcmd_md_i), .mdcfg_t_i(mdcfg_t_i),
    .entry_idx_o(entry_idx_o), .entry_addr_i(entry_addr_i),
    .entry_prev_addr_i(entry_prev_addr_i), .entry_cfg_i(entry_cfg_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_allow_o(rsp_allow_o),
    .rsp_hit_o(rsp_hit_o), .rsp_entry_o(rsp_entry_o), .rcd_we_o(rcd_we_o),
    .rcd_o(rcd_o), .rcd_addr_o(rcd_addr_o)
  );

  typedef struct {
    logic        allow;
    logic        hit;
    logic [4:0]  entry;
    logic        rcd_we;
    logic [2:0]  extra;
    logic        illcgt;
    logic        read;
    logic [13:0] sid;
    logic [12:0] len;
    logic [63:0] addr;
    int          lat_exact;
    int          hold;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  int exp_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: walk domains/entries as plain integers, matching on byte ranges.
  function automatic void model(input logic en, input logic [1:0] acc, input logic [63:0] addr,
                                input logic [12:0] len, input logic [13:0] sid, output exp_t e);
    logic [63:0] hi, a, p, base, top, size;
    int i, md, k;
    logic done, found, full, vld, perm;
    e = '{allow: 1'b0, hit: 1'b0, entry: 5'd0, rcd_we: 1'b0, extra: 3'b000, illcgt: 1'b0,
          read: (acc == 2'b01), sid: sid, len: len, addr: addr, lat_exact: -1, hold: 0, acc_cyc: 0};
    if (!en) begin
      e.allow = 1'b1;
      return;
    end
    if (acc == 2'b00 || acc == 2'b11) begin
      e.illcgt = 1'b1;
      e.rcd_we = 1'b1;
      return;
    end
    hi = addr + 64'(len);
    i = 0; md = 0; done = 0; found = 0; full = 0;
    while (!done) begin
      if (i >= NR_ENTRIES || md >= NR_MD) done = 1;
      else if (i >= int'(mdt[md])) md++;
      else begin
        a = ent_addr[i];
        p = (i == 0) ? 64'd0 : ent_addr[i-1];
        vld = 1'b1; base = 0; top = 0;
        case (ent_cfg[i].addr_mode)
          ADDR_TOR: begin base = p * 4; vld = (p * 4) < (a * 4); top = a * 4 - 1; end
          ADDR_NA4: begin base = a * 4; top = base + 3; end
          ADDR_NAPOT: begin
            k = 0;
            while (a[k]) k++;
            size = 64'd1 << (k + 3);
            base = (a * 4) & ~(size - 1);
            top = base + size - 1;
          end
          default: vld = 1'b0;
        endcase
        if (vld && srcmd_tab[sid[3:0]][md] && addr <= top && hi >= base) begin
          found = 1; done = 1;
          full = (addr >= base) && (hi <= top);
        end else i++;
      end
    end
    if (found) begin
      perm = (acc == 2'b01) ? ent_cfg[i].r : ent_cfg[i].w;
      e.hit = 1'b1;
      e.entry = 5'(i);
      e.allow = full && perm;
      e.extra = !full ? 3'b010 : (perm ? 3'b000 : 3'b001);
      e.rcd_we = !(full && perm);
    end else begin
      e.rcd_we = 1'b1;
    end
  endfunction

  // Monitor: compares every response cycle against the queue head; drives rsp_ready_i after hold.
  logic in_rsp = 1'b0;
  int hold_left = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_rsp = 1'b0;
      rsp_ready_i = 1'b0;
    end else begin
      if (rcd_we_o) pulses++;
      if (rsp_valid_o) begin
        if (q.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
        end else begin
          e = q[0];
          if (!in_rsp) begin
            in_rsp = 1'b1;
            hold_left = e.hold;
            if (e.lat_exact >= 0) check("latency", 64'(cyc - e.acc_cyc), 64'(e.lat_exact));
            else check("latency_bound", 64'((cyc - e.acc_cyc) <= LAT_MAX), 64'd1);
            check("rcd_we", 64'(rcd_we_o), 64'(e.rcd_we));
            if (e.rcd_we) begin
              check("rcd_sid", 64'(rcd_o.sid), 64'(e.sid));
              check("rcd_read", 64'(rcd_o.read), 64'(e.read));
              check("rcd_len", 64'(rcd_o.length), 64'(e.len));
              check("rcd_extra", 64'(rcd_o.extra), 64'(e.extra));
              check("rcd_illcgt", 64'(rcd_o.illcgt), 64'(e.illcgt));
              check("rcd_addr", rcd_addr_o, e.addr);
            end
          end
          check("allow", 64'(rsp_allow_o), 64'(e.allow));
          check("hit", 64'(rsp_hit_o), 64'(e.hit));
          if (e.hit) check("entry", 64'(rsp_entry_o), 64'(e.entry));
          check("ready_in_resp", 64'(req_ready_o), 64'd0);
          if (hold_left == 0) begin
            rsp_ready_i = 1'b1;
            void'(q.pop_front());
            in_rsp = 1'b0;
          end else begin
            hold_left--;
            rsp_ready_i = 1'b0;
          end
        end
      end else begin
        rsp_ready_i = 1'b0;
      end
    end
  end

  task automatic do_req(input logic en, input logic [1:0] acc, input logic [63:0] addr,
                        input logic [12:0] len, input logic [13:0] sid, input int lat_exact,
                        input int hold);
    exp_t e;
    int guard;
    model(en, acc, addr, len, sid, e);
    e.lat_exact = lat_exact;
    e.hold = hold;
    @(negedge clk);
    enable_i = en; req_addr_i = addr; req_len_i = len; req_sid_i = sid;
    req_access_i = iopmp_access_t'(acc);
    req_valid_i = 1'b1;
    guard = 0;
    while (!req_ready_o && guard < 200) begin @(negedge clk); guard++; end
    if (!req_ready_o) begin
      n_total++; n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
      req_valid_i = 1'b0;
      return;
    end
    e.acc_cyc = cyc + 1;
    q.push_back(e);
    if (e.rcd_we) exp_pulses++;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 300) begin @(negedge clk); guard++; end
    if (q.size() != 0) begin
      n_total++; n_bad++;
      $display("FAIL rsp_timeout: got no response expected one within %0d cycles", guard);
      q.delete();
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NR_ENTRIES; i++) begin
      ent_addr[i] = '0;
      ent_cfg[i] = '{addr_mode: ADDR_OFF, w: 1'b0, r: 1'b0};
    end
    for (int m = 0; m < NR_MD; m++) mdt[m] = 16'd0;
    for (int s = 0; s < 16; s++) srcmd_tab[s] = '0;
  endtask

  task automatic rand_cfg();
    int t;
    t = $urandom_range(0, 2);
    for (int m = 0; m < NR_MD; m++) begin
      t += $urandom_range(0, 2);
      if (t > NR_ENTRIES) t = NR_ENTRIES;
      mdt[m] = 16'(t);
    end
    for (int i = 0; i < NR_ENTRIES; i++) begin
      ent_addr[i] = 64'($urandom_range(0, 'hFFF));
      ent_cfg[i] = '{addr_mode: iopmp_addr_mode_t'($urandom_range(0, 3)),
                     w: 1'($urandom_range(0, 1)), r: 1'($urandom_range(0, 1))};
    end
    for (int s = 0; s < 16; s++) srcmd_tab[s] = {31'($urandom), 32'($urandom)};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    clear_cfg();
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rcd_we", 64'(rcd_we_o), 64'd0);
    check("rst_allow", 64'(rsp_allow_o), 64'd0);
    check("rst_sid", 64'(srcmd_sid_o), 64'd0);
    check("rst_rcd_addr", rcd_addr_o, 64'd0);
    rst = 1'b0;

    // Disabled checker passes everything after one cycle.
    do_req(1'b0, 2'b01, 64'h1000, 13'd0, 14'd5, 1, 0);

    // MD0 owns entries 0..1; entry0 NAPOT 0x1000-0x1FFF read-only.
    for (int m = 0; m < NR_MD; m++) mdt[m] = 16'd2;
    srcmd_tab[5] = 63'h1;
    srcmd_tab[6] = 63'h20;
    ent_addr[0] = 64'h5FF;
    ent_cfg[0] = '{addr_mode: ADDR_NAPOT, w: 1'b0, r: 1'b1};
    do_req(1'b1, 2'b01, 64'h1800, 13'd7, 14'd5, 3, 0);
    do_req(1'b1, 2'b10, 64'h1800, 13'd7, 14'd5, 3, 1);
    do_req(1'b1, 2'b01, 64'h1FFC, 13'd7, 14'd5, 3, 0);
    do_req(1'b1, 2'b01, 64'h1800, 13'd7, 14'd6, -1, 0);
    do_req(1'b1, 2'b00, 64'h1800, 13'd7, 14'd5, 1, 0);
    do_req(1'b1, 2'b11, 64'h1804, 13'd3, 14'd5, 1, 2);

    // Two empty domains skipped before MD2 reaches a TOR entry [0, 0x1000).
    clear_cfg();
    mdt[0] = 16'd0; mdt[1] = 16'd0;
    for (int m = 2; m < NR_MD; m++) mdt[m] = 16'd1;
    ent_addr[0] = 64'h400;
    ent_cfg[0] = '{addr_mode: ADDR_TOR, w: 1'b0, r: 1'b1};
    srcmd_tab[7] = 63'h4;
    do_req(1'b1, 2'b01, 64'h800, 13'd3, 14'd7, 5, 5);

    // Reset in the middle of a long scan: abandoned without response or record.
    for (int m = 0; m < NR_MD; m++) mdt[m] = 16'd32;
    @(negedge clk);
    enable_i = 1'b1; req_addr_i = 64'h9000; req_len_i = 13'd3; req_sid_i = 14'd7;
    req_access_i = ACCESS_READ; req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("midrst_req_ready", 64'(req_ready_o), 64'd1);
    check("midrst_rcd_we", 64'(rcd_we_o), 64'd0);
    check("midrst_idx", 64'(entry_idx_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (rsp_valid_o || rcd_we_o) seen = 1'b1;
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] acc;
      logic [12:0] len;
      if (n % 10 == 0) rand_cfg();
      acc = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
      len = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(0, 8191)) : 13'($urandom_range(0, 15));
      do_req(($urandom_range(0, 9) != 0), acc, 64'($urandom_range(0, 'h3FFF)), len,
             14'($urandom_range(0, 15)), -1, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("rcd_pulse_count", 64'(pulses), 64'(exp_pulses));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/iopmp_check_seq.md
IOPMP_CHECK_SEQ -- requirements
Module: iopmp_check_seq

Interface
REQ-001 SHALL have parameters NR_MD=63 (memory domains, ≤63), NR_ENTRIES=32 (entries, ≤32), ADDR_WIDTH=64 (request/entry address width).
REQ-002 SHALL use one clock and an asynchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-003 SHALL have the following request ports:
- enable_i  in  1  IOPMP_CTL.enable
- req_valid_i  in  1
- req_ready_o  out  1
- req_addr_i  in  ADDR_WIDTH  byte address
- req_len_i  in  13  bytes minus 1
- req_access_i  in  iopmp_access_t
- req_sid_i  in  14  source ID
REQ-004 SHALL have the following config read ports:
- srcmd_sid_o  out  14  SID lookup
- srcmd_md_i  in  63  same-cycle SRCMD.md
- mdcfg_t_i  in  NR_MD×16  MDCFG.T per domain
- entry_idx_o  out  5  entry index
- entry_addr_i  in  ADDR_WIDTH  ENTRY_ADDR[idx]
- entry_prev_addr_i  in  ADDR_WIDTH  ENTRY_ADDR[idx-1], 0 when idx=0
- entry_cfg_i  in  iopmp_entry_t
REQ-005 SHALL have the following response ports:
- rsp_valid_o  out  1
- rsp_ready_i  in  1
- rsp_allow_o  out  1
- rsp_hit_o  out  1  an entry matched
- rsp_entry_o  out  5  matching entry
- rcd_we_o  out  1  error-record strobe
- rcd_o  out  iopmp_rcd_t
- rcd_addr_o  out  ADDR_WIDTH

Function
REQ-006 SHALL use FSM states IDLE, LOOKUP, SCAN, RESP; req_ready_o=1 only in IDLE.
REQ-007 On req_valid_i&&req_ready_o, SHALL latch addr/len/access/sid and go to LOOKUP; srcmd_sid_o SHALL equal the latched SID.
REQ-008 In LOOKUP, if enable_i=0, SHALL go to RESP with allow=1, hit=0, and no scan.
REQ-009 In LOOKUP with enable_i=1, SHALL latch srcmd_md_i, set idx=0 and md=0, and go to SCAN.
REQ-010 In SCAN, each cycle SHALL apply exactly one of:
- (a) if idx≥NR_ENTRIES or md≥NR_MD: no match; go to RESP.
- (b) else if idx≥mdcfg_t_i[md]: md++, idx held (one cycle per skipped domain).
- (c) else evaluate entry idx, then idx++.
REQ-011 An entry SHALL be considered only if its cfg addr_mode≠OFF and latched md bit [md]=1; otherwise it is skipped.
REQ-012 Match rules, byte range [addr, addr+len]:
- TOR: prev<<2 ≤ lo and hi < entry<<2.
- NA4: the 4-byte region at entry<<2.
- NAPOT: region size set by trailing ones of entry_addr_i, per PMP.
- Full match = whole range inside region; partial = overlap but not full.
REQ-013 The first considered entry with full or partial overlap SHALL terminate the scan (lowest index wins) and set hit=1 and rsp_entry_o=idx.
REQ-014 allow=1 SHALL require a full match with access_type.r (read) or access_type.w (write); all other outcomes SHALL give allow=0.
REQ-015 req_access_i=ACCESS_NONE or 2'b11 SHALL give allow=0 with no scan (LOOKUP→RESP).
REQ-016 In RESP, rsp_valid_o=1 and the response SHALL be held stable until rsp_ready_i, then the FSM returns to IDLE; a new request SHALL not be accepted in the same cycle.
REQ-017 On each deny, the cycle the FSM enters RESP, SHALL pulse rcd_we_o for one cycle with rcd_o as follows:
- sid=latched SID
- read=(access==READ)
- length=req_len
- extra: 000 no hit, 001 permission, 010 partial
- illcgt=1 only for REQ-015
- rcd_addr_o=latched addr
REQ-018 Latency: accept at T; with enable=0, rsp_valid at T+1; a match on entry 0 of non-empty MD0 gives rsp_valid at T+3; the worst case is bounded by 2+NR_ENTRIES+NR_MD.
REQ-019 Config inputs SHALL be sampled live during SCAN; software changing config mid-scan affects only that transaction's result.

Reset
REQ-020 While rst_i is high, SHALL hold the FSM in IDLE, req_ready_o=1, and all other outputs and registers 0, with no rcd_we_o pulse; a reset mid-scan SHALL abandon the transaction silently.

Structure
REQ-021 FSM state enum and extra-code constants SHALL be added to iopmp_pkg; iopmp_access_t, iopmp_entry_t, and iopmp_rcd_t SHALL be reused.
REQ-022 Range matching SHALL be a combinational sub-module iopmp_entry_match (inputs: lo, hi, entry_addr, prev_addr, mode; outputs: full, partial).

Verification
REQ-023 enable_i=0, read of 0x1000 → rsp at T+1, allow=1, hit=0, no rcd_we_o.
REQ-024 MD0 T=2, SRCMD md[0]=1, entry0 NAPOT 0x1000–0x1FFF r=1; read 0x1800 len 7 → rsp at T+3, allow=1, entry=0.
REQ-025 Same config, write to 0x1800 → allow=0, rcd_we_o pulse, extra=001, read=0, sid echoed.
REQ-026 Read 0x1FFC len 7 → partial match, allow=0, extra=010; with no entries in the SID's domains → extra=000 after the full scan.
REQ-027 MD0 T=0, MD1 T=0, MD2 T=1 with entry0 a TOR match, md[2]=1 → two skip cycles, then hit entry0; rsp_ready_i held low 5 cycles → response stable.
REQ-028 Assert rst_i mid-SCAN → IDLE next edge, no rsp_valid_o, no rcd_we_o.
